ccr_branch_unit: RTL

Condition Control Register and branch resolver. It sits downstream of the ALU and consumes its flag outputs (N, Z, V, C, INR) and CCR_Enable. It accepts branch/jump requests from the control unit, waits for the ALU compare result when the branch is conditional, and returns the next-PC, taken, and link decision through a valid/ready handshake.

---
 rtl/ccr_pkg.sv | 61 ++++++
 rtl/ccr_flag_reg.sv | 56 +++++
 rtl/ccr_branch_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ccr_pkg.sv
// ccr_pkg
// Shared definitions for the condition-code register and branch resolver:
// branch opcodes, CCR bit positions, FSM state encoding and the small
// opcode-decode helpers used by the top module.
package ccr_pkg;

  // Branch opcodes, aligned with the ALU opcode space.
  localparam logic [31:0] OP_JMP = 32'd16;
  localparam logic [31:0] OP_JSR = 32'd17;
  localparam logic [31:0] OP_RTS = 32'd18;
  localparam logic [31:0] OP_BEQ = 32'd39;
  localparam logic [31:0] OP_BNE = 32'd40;
  localparam logic [31:0] OP_BLT = 32'd41;
  localparam logic [31:0] OP_BRA = 32'd64;
  localparam logic [31:0] OP_BSR = 32'd65;

  // CCR bit positions.
  localparam int CCR_C    = 0;
  localparam int CCR_V    = 1;
  localparam int CCR_Z    = 2;
  localparam int CCR_N    = 3;
  localparam int CCR_INR  = 4;
  localparam int CCR_IFNR = 5;
  localparam int CCR_NOP  = 6;
  localparam int CCR_TMO  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CC = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  function automatic logic is_uncond(input logic [31:0] op);
    return (op == OP_JMP) || (op == OP_JSR) || (op == OP_RTS) ||
           (op == OP_BRA) || (op == OP_BSR);
  endfunction

  function automatic logic is_cond(input logic [31:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT);
  endfunction

  function automatic logic is_link(input logic [31:0] op);
    return (op == OP_JSR) || (op == OP_BSR);
  endfunction

  // Branch condition against a set of ALU flags; non-conditional ops
  // never reach this path.
  function automatic logic cond_met(input logic [31:0] op, input logic n,
                                    input logic z, input logic v);
    logic met;
    met = 1'b0;
    case (op)
      OP_BEQ:  met = z;
      OP_BNE:  met = ~z;
      OP_BLT:  met = n ^ v;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/ccr_flag_reg.sv
// ccr_flag_reg
// The 8-bit condition-code register. ALU flags load on a non-NOP update
// strobe, the NOP bit tracks NOP_FLAG every cycle, IFNR and TMO are sticky
// until cleared, and a synchronous clear beats every other update.
// Ports:
//   Clock, Resetn      clock, async active-low reset
//   i_enable, i_nop    flag-update strobe and NOP qualifier
//   i_n/i_z/i_v/i_c/i_inr  incoming ALU flags
//   i_clear            synchronous clear of all eight bits
//   i_set_ifnr         set the sticky illegal-opcode bit
//   i_set_tmo          set the sticky timeout bit
//   o_ccr              current register value
module ccr_flag_reg
  import ccr_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       i_enable,
  input  logic       i_nop,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_v,
  input  logic       i_c,
  input  logic       i_inr,
  input  logic       i_clear,
  input  logic       i_set_ifnr,
  input  logic       i_set_tmo,
  output logic [7:0] o_ccr
);

  logic [7:0] r_ccr;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ccr <= '0;
    end else if (i_clear) begin
      r_ccr <= '0;
    end else begin
      if (i_enable && !i_nop) begin
        r_ccr[CCR_C]   <= i_c;
        r_ccr[CCR_V]   <= i_v;
        r_ccr[CCR_Z]   <= i_z;
        r_ccr[CCR_N]   <= i_n;
        r_ccr[CCR_INR] <= i_inr;
      end
      r_ccr[CCR_NOP] <= i_nop;
      if (i_set_ifnr) r_ccr[CCR_IFNR] <= 1'b1;
      if (i_set_tmo)  r_ccr[CCR_TMO]  <= 1'b1;
    end
  end

  assign o_ccr = r_ccr;

endmodule

// File: rtl/ccr_branch_unit.sv
// ccr_branch_unit
// Condition-code register plus branch resolver. Accepts a branch request
// over Br_Valid/Br_Ready, waits for the next ALU flag strobe when the
// branch is conditional (bounded by TIMEOUT), and then emits a one-cycle
// registered resolve pulse carrying taken, next-PC and link information.
// Ports:
//   Clock, Resetn                 clock, async active-low reset
//   CCR_Enable, NOP_FLAG          ALU flag strobe and NOP qualifier
//   NEGATIVE/ZERO/OVERFLOW/CARRY/INR_FLAG  ALU flags
//   CCR_Clear                     synchronous CCR clear
//   Br_Valid, Br_Ready            request handshake
//   Br_Op, Br_Target, PC_Plus     request payload
//   Br_Done, Br_Taken, PC_Load    resolve pulse and decision
//   PC_Next                       resolved next PC
//   Link_Write, Link_Data         link-register write for JSR/BSR
//   CCR                           {24'b0, TMO, NOP, IFNR, INR, N, Z, V, C}
module ccr_branch_unit
  import ccr_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              CCR_Enable,
  input  logic              NOP_FLAG,
  input  logic              NEGATIVE_FLAG,
  input  logic              ZERO_FLAG,
  input  logic              OVERFLOW_FLAG,
  input  logic              CARRY_FLAG,
  input  logic              INR_FLAG,
  input  logic              CCR_Clear,
  input  logic              Br_Valid,
  input  logic [OP_W-1:0]   Br_Op,
  input  logic [DATA_W-1:0] Br_Target,
  input  logic [DATA_W-1:0] PC_Plus,
  output logic              Br_Ready,
  output logic              Br_Done,
  output logic              Br_Taken,
  output logic              PC_Load,
  output logic [DATA_W-1:0] PC_Next,
  output logic              Link_Write,
  output logic [DATA_W-1:0] Link_Data,
  output logic [31:0]       CCR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_target;
  logic [DATA_W-1:0]   r_pc_plus;
  logic                r_taken;     // pending decision for the RESOLVE cycle
  logic                r_tmo;       // pending decision came from a timeout
  logic                r_ifnr;      // pending request had an unknown opcode
  logic                r_done;
  logic                r_br_taken;
  logic                r_pc_load;
  logic [DATA_W-1:0]   r_pc_next;
  logic                r_link_write;
  logic [DATA_W-1:0]   r_link_data;
  logic [7:0]          w_ccr;

  logic                w_accept;
  logic                w_strobe;
  logic                w_timeout;
  logic [31:0]         w_in_op;
  logic [31:0]         w_cur_op;

  assign w_in_op  = 32'(Br_Op);
  assign w_cur_op = 32'(r_op);
  assign w_strobe = CCR_Enable && !NOP_FLAG;
  assign w_accept = Br_Valid && Br_Ready;
  // A real flag strobe wins over a timeout landing in the same cycle.
  assign w_timeout = (r_state == WAIT_CC) && !w_strobe &&
                     (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  // Ready also stays low during the resolve pulse so the registered
  // outputs are never overwritten while they are still being consumed.
  assign Br_Ready = (r_state == IDLE) && !r_done;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path through the case can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = is_cond(w_in_op) ? WAIT_CC : RESOLVE;
      end
      WAIT_CC: begin
        if (w_strobe || w_timeout) w_state_next = RESOLVE;
      end
      RESOLVE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture, wait counter and pending decision.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_op       <= '0;
      r_target   <= '0;
      r_pc_plus  <= '0;
      r_wait_cnt <= '0;
      r_taken    <= 1'b0;
      r_tmo      <= 1'b0;
      r_ifnr     <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_op       <= Br_Op;
        r_target   <= Br_Target;
        r_pc_plus  <= PC_Plus;
        r_wait_cnt <= '0;
        r_taken    <= is_uncond(w_in_op);
        r_tmo      <= 1'b0;
        r_ifnr     <= !is_uncond(w_in_op) && !is_cond(w_in_op);
      end
    end else if (r_state == WAIT_CC) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_strobe) begin
        // Evaluated on the incoming flags, not the CCR, so a simultaneous
        // CCR_Clear does not affect the decision.
        r_taken <= cond_met(w_cur_op, NEGATIVE_FLAG, ZERO_FLAG, OVERFLOW_FLAG);
      end else if (w_timeout) begin
        r_taken <= 1'b0;
        r_tmo   <= 1'b1;
      end
    end
  end

  // Registered resolve outputs; the pulse fields drop the cycle after.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_done       <= 1'b0;
      r_br_taken   <= 1'b0;
      r_pc_load    <= 1'b0;
      r_pc_next    <= '0;
      r_link_write <= 1'b0;
      r_link_data  <= '0;
    end else if (r_state == RESOLVE) begin
      r_done       <= 1'b1;
      r_br_taken   <= r_taken;
      r_pc_load    <= r_taken;
      r_pc_next    <= r_taken ? r_target : r_pc_plus;
      r_link_write <= is_link(w_cur_op);
      r_link_data  <= r_pc_plus;
    end else begin
      r_done       <= 1'b0;
      r_br_taken   <= 1'b0;
      r_pc_load    <= 1'b0;
      r_link_write <= 1'b0;
    end
  end

  ccr_flag_reg u_flag_reg (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .i_enable   (CCR_Enable),
    .i_nop      (NOP_FLAG),
    .i_n        (NEGATIVE_FLAG),
    .i_z        (ZERO_FLAG),
    .i_v        (OVERFLOW_FLAG),
    .i_c        (CARRY_FLAG),
    .i_inr      (INR_FLAG),
    .i_clear    (CCR_Clear),
    // Sticky bits land on the same edge as the resolve pulse.
    .i_set_ifnr ((r_state == RESOLVE) && r_ifnr),
    .i_set_tmo  ((r_state == RESOLVE) && r_tmo),
    .o_ccr      (w_ccr)
  );

  assign Br_Done    = r_done;
  assign Br_Taken   = r_br_taken;
  assign PC_Load    = r_pc_load;
  assign PC_Next    = r_pc_next;
  assign Link_Write = r_link_write;
  assign Link_Data  = r_link_data;
  assign CCR        = {24'd0, w_ccr};

endmodule
